// File: rtl/parity_generator_if.sv
// Word/parity handshake between a producer and the parity generator.
interface parity_generator_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              chk_en;
  logic              parity_in;
  logic              clr_count;
  logic              even_parity;
  logic              odd_parity;
  logic              out_valid;
  logic              parity_err;
  logic [CNT_W-1:0]  err_count;

  // Producer side: drives words, observes parity results.
  modport master (
    output in_valid, data_in, chk_en, parity_in, clr_count,
    input  even_parity, odd_parity, out_valid, parity_err, err_count
  );

  // Parity generator side.
  modport slave (
    input  in_valid, data_in, chk_en, parity_in, clr_count,
    output even_parity, odd_parity, out_valid, parity_err, err_count
  );
endinterface

// File: rtl/parity_generator.sv
// Registered even/odd parity generator with optional received-parity check
// and a saturating error counter.
module parity_generator #(
  parameter int unsigned DATA_W    = 4,
  parameter bit          CHECK_ODD = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  parity_generator_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             even_q;
  logic             odd_q;
  logic             valid_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic ep_c;
  logic exp_c;
  logic mismatch_c;

  // Parity of the incoming word and the checker's verdict on it.
  always_comb begin
    ep_c       = ^bus.data_in;
    exp_c      = CHECK_ODD ? ~ep_c : ep_c;
    mismatch_c = bus.in_valid & bus.chk_en & (bus.parity_in != exp_c);
  end

  // Parity/valid/error registers; parity and error hold when no word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_q  <= 1'b0;
      odd_q   <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        even_q <= ep_c;
        odd_q  <= ~ep_c;
        err_q  <= mismatch_c;
      end
    end
  end

  // Saturating error counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_count) begin
      cnt_q <= '0;
    end else if (mismatch_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.even_parity = even_q;
  assign bus.odd_parity  = odd_q;
  assign bus.out_valid   = valid_q;
  assign bus.parity_err  = err_q;
  assign bus.err_count   = cnt_q;

endmodule

// File: tb/tb_parity_generator.sv
// Bench for parity_generator: directed scenarios then random words, two
// configurations (even check / 8-bit count, odd check / 2-bit count).
module tb_parity_generator;

  localparam int unsigned DW = 4;

  logic clk;
  logic rst_n;

  parity_generator_if #(.DATA_W(DW), .CNT_W(8)) if0 ();
  parity_generator_if #(.DATA_W(DW), .CNT_W(2)) if1 ();

  parity_generator #(.DATA_W(DW), .CHECK_ODD(1'b0), .CNT_W(8)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  parity_generator #(.DATA_W(DW), .CHECK_ODD(1'b1), .CNT_W(2)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Current stimulus, kept by the bench for its model.
  logic          s_v;
  logic [DW-1:0] s_d;
  logic          s_chk;
  logic          s_p [2];
  logic          s_clr;

  // Reference model: parity from a population count.
  int m_even  [2];
  int m_valid;
  int m_err   [2];
  int m_cnt   [2];
  int cnt_max [2] = '{255, 3};
  int chk_odd [2] = '{0, 1};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_even[k] = 0;
      m_err[k]  = 0;
      m_cnt[k]  = 0;
    end
    m_valid = 0;
  endfunction

  function automatic void model_step();
    int ep;
    int expp;
    int mis;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ep = $countones(s_d) % 2;
    for (int k = 0; k < 2; k++) begin
      expp = (chk_odd[k] != 0) ? 1 - ep : ep;
      mis  = (s_v && s_chk && (int'(s_p[k]) != expp)) ? 1 : 0;
      if (s_v) begin
        m_even[k] = ep;
        m_err[k]  = mis;
      end
      if (s_clr) m_cnt[k] = 0;
      else if (mis != 0 && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
    end
    m_valid = s_v ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".d0.even"}, 32'(if0.even_parity), 32'(m_even[0]));
    check({tag, ".d0.odd"},  32'(if0.odd_parity),  32'(1 - m_even[0]));
    check({tag, ".d0.vld"},  32'(if0.out_valid),   32'(m_valid));
    check({tag, ".d0.err"},  32'(if0.parity_err),  32'(m_err[0]));
    check({tag, ".d0.cnt"},  32'(if0.err_count),   32'(m_cnt[0]));
    check({tag, ".d1.even"}, 32'(if1.even_parity), 32'(m_even[1]));
    check({tag, ".d1.odd"},  32'(if1.odd_parity),  32'(1 - m_even[1]));
    check({tag, ".d1.vld"},  32'(if1.out_valid),   32'(m_valid));
    check({tag, ".d1.err"},  32'(if1.parity_err),  32'(m_err[1]));
    check({tag, ".d1.cnt"},  32'(if1.err_count),   32'(m_cnt[1]));
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic chk,
                       input logic p0, input logic p1, input logic clr);
    s_v = v; s_d = d; s_chk = chk; s_p[0] = p0; s_p[1] = p1; s_clr = clr;
    if0.in_valid = v; if0.data_in = d; if0.chk_en = chk; if0.parity_in = p0; if0.clr_count = clr;
    if1.in_valid = v; if1.data_in = d; if1.chk_en = chk; if1.parity_in = p1; if1.clr_count = clr;
  endtask

  // One clock: model and DUT update on the edge, outputs sampled 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Word with a mismatching parity bit for both configurations.
  task automatic drive_mismatch(input logic [DW-1:0] d, input logic clr);
    logic ep;
    ep = ($countones(d) % 2) != 0;
    drive(1'b1, d, 1'b1, ~ep, ep, clr);
  endtask

  logic [DW-1:0] words [5] = '{4'b0000, 4'b0001, 4'b1010, 4'b1111, 4'b1101};
  logic [4:0]    exp_even = 5'b10010;
  int            sat_seq [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    cycle("idle");

    // Successive words, latency 1, continuous out_valid.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0, 1'b0, 1'b0);
      cycle($sformatf("seq%0d", i));
      check($sformatf("seq%0d.even_const", i), 32'(if0.even_parity), 32'(exp_even[i]));
      check($sformatf("seq%0d.vld_const", i),  32'(if0.out_valid),   32'd1);
    end

    // Even-parity check of 1101: correct bit, then wrong bit.
    drive(1'b1, 4'b1101, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("chk_ok");
    check("chk_ok.err_const", 32'(if0.parity_err), 32'd0);
    drive(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("chk_bad");
    check("chk_bad.err_const", 32'(if0.parity_err), 32'd1);
    check("chk_bad.cnt_const", 32'(if0.err_count),  32'd1);

    // No accept: parity and error hold.
    drive(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle("hold");
    check("hold.even_const", 32'(if0.even_parity), 32'd1);
    check("hold.vld_const",  32'(if0.out_valid),   32'd0);
    check("hold.cnt_const",  32'(if0.err_count),   32'd1);

    // Saturation of the 2-bit counter, then clear beating an increment.
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle("clr");
    for (int i = 0; i < 5; i++) begin
      drive_mismatch(4'(i + 3), 1'b0);
      cycle($sformatf("sat%0d", i));
      check($sformatf("sat%0d.cnt_const", i), 32'(if1.err_count), 32'(sat_seq[i]));
    end
    drive_mismatch(4'b0110, 1'b1);
    cycle("clr_pri");
    check("clr_pri.cnt_const", 32'(if1.err_count), 32'd0);
    check("clr_pri.err_const", 32'(if1.parity_err), 32'd1);

    // Build err_count=2 with even_parity=1, then async reset between edges.
    drive_mismatch(4'b0001, 1'b0);
    cycle("pre_rst0");
    drive_mismatch(4'b0111, 1'b0);
    cycle("pre_rst1");
    check("pre_rst.cnt_const",  32'(if0.err_count),   32'd2);
    check("pre_rst.even_const", 32'(if0.even_parity), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.cnt_const", 32'(if0.err_count),  32'd0);
    check("async_rst.odd_const", 32'(if0.odd_parity), 32'd1);
    cycle("in_rst");
    #3;
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle("post_rst");

    // Random words against the model.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));
      cycle($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
